// File: rtl/pwm_capture_1000_pkg.sv
// Shared PWM constants (generator and capture side) and the capture FSM state type.
package pwm_capture_1000_pkg;

   localparam int unsigned SYS_CLK_FREQ  = 100_000_000;
   localparam int unsigned PERMILLE_FULL = 1000;
   localparam int unsigned DUTY_W        = 10;

   typedef enum logic [1:0] {
      StIdle,
      StMeasure,
      StDivide
   } cap_state_t;

endpackage

// File: rtl/edge_detector_p.sv
// Registers d once and flags single-cycle rising and falling edges.
module edge_detector_p (
   input  logic clk,
   input  logic reset_p,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic d_q;

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) d_q <= 1'b0;
      else         d_q <= d;
   end

   assign rise = d & ~d_q;
   assign fall = ~d & d_q;

endmodule

// File: rtl/pwm_capture_1000_div.sv
// Ten-step restoring divider, one quotient bit per clock, MSB first.
// Bit 9 is resolved on the start edge, so done rises 10 cycles after start.
module pwm_div_permille
   import pwm_capture_1000_pkg::*;
#(
   parameter int unsigned CNT_W = 27
) (
   input  logic                     clk,
   input  logic                     reset_p,
   input  logic                     start,
   input  logic [CNT_W+DUTY_W-1:0]  dividend,
   input  logic [CNT_W-1:0]         divisor,
   output logic                     done,
   output logic [DUTY_W-1:0]        quotient
);

   localparam int unsigned REM_W = CNT_W + DUTY_W;

   logic [REM_W-1:0] rem, cur_rem, trial;
   logic [CNT_W-1:0] dsr, cur_dsr;
   logic [3:0]       idx, cur_idx;
   logic             busy, ge;

   always_comb begin
      cur_rem = start ? dividend : rem;
      cur_dsr = start ? divisor : dsr;
      cur_idx = start ? 4'(DUTY_W - 1) : idx;
      trial   = REM_W'(cur_dsr) << cur_idx;
      ge      = cur_rem >= trial;
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         rem      <= '0;
         dsr      <= '0;
         idx      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         quotient <= '0;
      end else begin
         done <= 1'b0;
         if (start || busy) begin
            rem <= ge ? cur_rem - trial : cur_rem;
            dsr <= cur_dsr;
            if (start) quotient <= '0;
            quotient[cur_idx] <= ge;
            if (cur_idx == 4'd0) begin
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               busy <= 1'b1;
               idx  <= cur_idx - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/pwm_capture_1000.sv
// PWM capture: measures period and high time of an async PWM input and
// reports duty in permille once per completed period, with timeout and overrun flags.
module pwm_capture_1000 #(
   parameter int unsigned SYS_CLK_FREQ = pwm_capture_1000_pkg::SYS_CLK_FREQ,
   parameter int unsigned CNT_W        = 27,
   parameter int unsigned TIMEOUT_CYC  = SYS_CLK_FREQ
) (
   input  logic                                   clk,
   input  logic                                   reset_p,
   input  logic                                   pwm_in,
   output logic [pwm_capture_1000_pkg::DUTY_W-1:0] duty_permille,
   output logic [CNT_W-1:0]                       period_cycles,
   output logic                                   valid,
   output logic                                   timeout,
   output logic                                   overrun
);

   import pwm_capture_1000_pkg::*;

   localparam int unsigned     DIV_W = CNT_W + DUTY_W;
   localparam logic [CNT_W-1:0] TMO  = CNT_W'(TIMEOUT_CYC);

   logic              sync0, s, rise, fall;
   logic [CNT_W-1:0]  per_cnt, hi_cnt, hi_lat, per_lat, div_hi;
   logic              fell, div_start, div_done, tmo_hit;
   logic [DIV_W-1:0]  dividend;
   logic [DUTY_W-1:0] quotient;
   cap_state_t        state;

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         sync0 <= 1'b0;
         s     <= 1'b0;
      end else begin
         sync0 <= pwm_in;
         s     <= sync0;
      end
   end

   edge_detector_p u_edge (
      .clk     (clk),
      .reset_p (reset_p),
      .d       (s),
      .rise    (rise),
      .fall    (fall)
   );

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         per_cnt <= '0;
         hi_cnt  <= '0;
         hi_lat  <= '0;
         fell    <= 1'b0;
      end else begin
         if (rise)                per_cnt <= CNT_W'(1);
         else if (per_cnt != TMO) per_cnt <= per_cnt + CNT_W'(1);
         if (rise)                     hi_cnt <= CNT_W'(1);
         else if (s && hi_cnt != TMO)  hi_cnt <= hi_cnt + CNT_W'(1);
         if (rise) begin
            fell <= 1'b0;
         end else if (fall) begin
            fell   <= 1'b1;
            hi_lat <= hi_cnt;
         end
      end
   end

   // A period with no fall was high throughout, so its high time equals its length.
   assign div_hi    = fell ? hi_lat : per_cnt;
   assign dividend  = DIV_W'(div_hi) * DIV_W'(PERMILLE_FULL);
   assign div_start = (state == StMeasure) && rise;
   assign tmo_hit   = !rise && !timeout && (per_cnt == TMO) && (state != StDivide);

   pwm_div_permille #(
      .CNT_W (CNT_W)
   ) u_div (
      .clk      (clk),
      .reset_p  (reset_p),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (per_cnt),
      .done     (div_done),
      .quotient (quotient)
   );

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state         <= StIdle;
         per_lat       <= '0;
         duty_permille <= '0;
         period_cycles <= '0;
         valid         <= 1'b0;
         timeout       <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         valid   <= 1'b0;
         overrun <= 1'b0;
         case (state)
            StIdle: begin
               if (rise) state <= StMeasure;
            end
            StMeasure: begin
               if (rise) begin
                  per_lat <= per_cnt;
                  state   <= StDivide;
               end
            end
            StDivide: begin
               if (rise) overrun <= 1'b1;
               if (div_done) begin
                  duty_permille <= quotient;
                  period_cycles <= per_lat;
                  valid         <= 1'b1;
                  state         <= StMeasure;
               end
            end
            default: state <= StIdle;
         endcase
         if (rise) begin
            timeout <= 1'b0;
         end else if (tmo_hit) begin
            timeout       <= 1'b1;
            duty_permille <= s ? DUTY_W'(PERMILLE_FULL) : '0;
            period_cycles <= '0;
            valid         <= 1'b1;
            state         <= StIdle;
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture_1000.sv
// Bench for pwm_capture_1000: table-driven PWM periods plus timeout, overrun and
// reset-during-divide sequences, checked against a queue of expected reports.
module tb_pwm_capture_1000;

   localparam int unsigned CNT_W = 27;
   localparam int unsigned TMO   = 5000;

   logic             clk = 1'b0;
   logic             reset_p = 1'b1;
   logic             pwm_in = 1'b0;
   logic [9:0]       duty_permille;
   logic [CNT_W-1:0] period_cycles;
   logic             valid, timeout, overrun;

   always #5 clk = ~clk;

   pwm_capture_1000 #(
      .SYS_CLK_FREQ (100_000_000),
      .CNT_W        (CNT_W),
      .TIMEOUT_CYC  (TMO)
   ) dut (
      .clk           (clk),
      .reset_p       (reset_p),
      .pwm_in        (pwm_in),
      .duty_permille (duty_permille),
      .period_cycles (period_cycles),
      .valid         (valid),
      .timeout       (timeout),
      .overrun       (overrun)
   );

   typedef struct {
      int duty;
      int period;
      bit tmo;
   } exp_t;

   typedef struct {
      int hi;
      int lo;
      int reps;
      int duty;
      int period;
   } vec_t;

   exp_t sb[$];
   exp_t prev;
   bit   have_prev = 1'b0;
   int   checks = 0;
   int   failures = 0;
   int   n_overrun = 0;
   vec_t vecs[4];

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t mk(input int d, input int p, input bit t);
      exp_t e;
      e.duty   = d;
      e.period = p;
      e.tmo    = t;
      return e;
   endfunction

   // Scoreboard: every valid pops one expected report.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_p) begin
         if (overrun) n_overrun++;
         if (valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("duty", duty_permille, e.duty);
               check("period", period_cycles, e.period);
               check("timeout_at_valid", timeout, e.tmo);
            end
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_period(input int hi, input int lo, input int d, input int p);
      pwm_in = 1'b1;
      if (have_prev) sb.push_back(prev);
      hold(hi);
      pwm_in = 1'b0;
      hold(lo);
      prev      = mk(d, p, 1'b0);
      have_prev = 1'b1;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 7000; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
      end
      #1;
      check(name, sb.size(), 0);
      sb.delete();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_duty"}, duty_permille, 0);
      check({tag, "_period"}, period_cycles, 0);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_overrun"}, overrun, 0);
   endtask

   // Final rise reports the last period, then the held-high line times out at 1000.
   task automatic finish_high(input string name);
      pwm_in = 1'b1;
      if (have_prev) sb.push_back(prev);
      have_prev = 1'b0;
      sb.push_back(mk(1000, 0, 1'b1));
      hold(4990);
      check({name, "_early"}, timeout, 0);
      wait_drain(name);
      check({name, "_level"}, timeout, 1);
   endtask

   initial begin
      vecs[0] = '{300, 700, 3, 300, 1000};
      vecs[1] = '{1, 2999, 2, 0, 3000};
      vecs[2] = '{2999, 1, 2, 999, 3000};
      vecs[3] = '{1000, 3000, 2, 250, 4000};

      reset_p = 1'b1;
      pwm_in  = 1'b0;
      hold(3);
      check_zero("reset");
      reset_p = 1'b0;
      hold(2);

      for (int v = 0; v < 4; v++)
         for (int r = 0; r < vecs[v].reps; r++)
            drive_period(vecs[v].hi, vecs[v].lo, vecs[v].duty, vecs[v].period);
      finish_high("tmo_high");

      // Constant low after one rise: timeout clears on the rise, then reports 0.
      pwm_in = 1'b0;
      hold(20);
      check("tmo_held", timeout, 1);
      pwm_in = 1'b1;
      hold(8);
      check("tmo_clear", timeout, 0);
      hold(12);
      pwm_in = 1'b0;
      sb.push_back(mk(0, 0, 1'b1));
      hold(4900);
      check("tmo_low_early", timeout, 0);
      wait_drain("tmo_low");

      // Period 8 is shorter than a division: every other period is dropped.
      for (int k = 0; k < 9; k++) begin
         pwm_in = 1'b1;
         if (k % 2 == 1) sb.push_back(mk(375, 8, 1'b0));
         hold(3);
         pwm_in = 1'b0;
         hold(5);
      end
      sb.push_back(mk(0, 0, 1'b1));
      wait_drain("overrun_seq");
      check("overrun_count", n_overrun, 4);

      // Reset four cycles into a division drops the result.
      have_prev = 1'b0;
      drive_period(300, 700, 300, 1000);
      have_prev = 1'b0;
      pwm_in = 1'b1;
      hold(7);
      reset_p = 1'b1;
      hold(2);
      check_zero("mid_div_reset");
      reset_p = 1'b0;
      hold(200);
      pwm_in = 1'b0;
      hold(800);
      prev      = mk(200, 1000, 1'b0);
      have_prev = 1'b1;
      drive_period(400, 600, 400, 1000);
      finish_high("after_reset");
      check("overrun_total", n_overrun, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
